digit_serial_adder: RTL and testbench

DIGIT_SERIAL_ADDER -- requirements
Module: digit_serial_adder

---
 rtl/digit_serial_adder.sv | 100 ++++++++++
 tb/tb_digit_serial_adder.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/digit_serial_adder.sv
// Digit-serial unsigned adder: adds two W-bit operands one 2-bit digit per cycle,
// with a ready/valid handshake on both the operand and the result side.
module digit_serial_adder #(
  parameter int N_DIGITS = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    io_in_valid,
  output logic                    io_in_ready,
  input  logic [2*N_DIGITS-1:0]   io_lhs,
  input  logic [2*N_DIGITS-1:0]   io_rhs,
  input  logic                    io_cin,
  output logic                    io_out_valid,
  input  logic                    io_out_ready,
  output logic [2*N_DIGITS-1:0]   io_out,
  output logic                    io_cout
);

  localparam int W     = 2 * N_DIGITS;
  localparam int CNT_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t             r_state;
  state_t             w_next_state;
  logic [W-1:0]       r_lhs;
  logic [W-1:0]       r_rhs;
  logic [W-1:0]       r_result;
  logic               r_carry;
  logic [CNT_W-1:0]   r_cnt;

  logic               w_accept;
  logic               w_last;
  logic [CNT_W:0]     w_base;
  logic [2:0]         w_sum;

  assign w_accept = io_in_valid && (r_state == S_IDLE);
  assign w_last   = (r_cnt == CNT_W'(N_DIGITS - 1));
  assign w_base   = {r_cnt, 1'b0};
  assign w_sum    = {1'b0, r_lhs[w_base +: 2]} + {1'b0, r_rhs[w_base +: 2]} + {2'b00, r_carry};

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of block ordering.
  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next_state;
  end

  // NOTE: every combinational output gets a default first so no path leaves
  // it unassigned, which would infer a latch.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:  if (io_in_valid)  w_next_state = S_RUN;
      S_RUN:   if (w_last)       w_next_state = S_DONE;
      S_DONE:  if (io_out_ready) w_next_state = S_IDLE;
      default:                   w_next_state = S_IDLE;
    endcase
  end

  always_comb begin
    io_in_ready  = 1'b0;
    io_out_valid = 1'b0;
    case (r_state)
      S_IDLE:  io_in_ready  = 1'b1;
      S_DONE:  io_out_valid = 1'b1;
      default: ;
    endcase
  end

  // Operands, carry and result only move on accept or while running, so the
  // outputs hold through DONE and the following IDLE.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_lhs    <= '0;
      r_rhs    <= '0;
      r_result <= '0;
      r_carry  <= 1'b0;
      r_cnt    <= '0;
    end else if (w_accept) begin
      r_lhs    <= io_lhs;
      r_rhs    <= io_rhs;
      r_result <= '0;
      r_carry  <= io_cin;
      r_cnt    <= '0;
    end else if (r_state == S_RUN) begin
      r_result[w_base +: 2] <= w_sum[1:0];
      r_carry               <= w_sum[2];
      r_cnt                 <= r_cnt + CNT_W'(1);
    end
  end

  assign io_out  = r_result;
  assign io_cout = r_carry;

endmodule

// File: tb/tb_digit_serial_adder.sv
// Randomized self-checking bench for digit_serial_adder; expected sums come from
// plain integer addition of the operands and carry-in.
module tb_digit_serial_adder;

  localparam int N_DIGITS = 4;
  localparam int W        = 2 * N_DIGITS;
  localparam int LAT      = N_DIGITS + 1;
  localparam int TIMEOUT  = 40;

  logic         clk = 1'b0;
  logic         reset;
  logic         io_in_valid;
  logic         io_in_ready;
  logic [W-1:0] io_lhs;
  logic [W-1:0] io_rhs;
  logic         io_cin;
  logic         io_out_valid;
  logic         io_out_ready;
  logic [W-1:0] io_out;
  logic         io_cout;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  digit_serial_adder #(.N_DIGITS(N_DIGITS)) dut (
    .clk          (clk),
    .reset        (reset),
    .io_in_valid  (io_in_valid),
    .io_in_ready  (io_in_ready),
    .io_lhs       (io_lhs),
    .io_rhs       (io_rhs),
    .io_cin       (io_cin),
    .io_out_valid (io_out_valid),
    .io_out_ready (io_out_ready),
    .io_out       (io_out),
    .io_cout      (io_cout)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [W:0] model_sum(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic c);
    return {1'b0, a} + {1'b0, b} + {{W{1'b0}}, c};
  endfunction

  // Waits (on falling edges) until io_in_ready, offers one operand set, then
  // scrambles the inputs every cycle until io_out_valid. Leaves out_ready as found.
  task automatic issue_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                          output int lat, output int hs_cyc, output bit ok);
    int waited = 0;
    ok  = 1'b1;
    lat = 0;
    while (!io_in_ready && waited < TIMEOUT) begin
      @(negedge clk);
      waited++;
    end
    if (!io_in_ready) begin
      n_checks++; n_fail++;
      $display("FAIL in_ready_timeout: in_ready=%0b required 1", io_in_ready);
      ok = 1'b0;
      return;
    end
    io_in_valid = 1'b1;
    io_lhs      = a;
    io_rhs      = b;
    io_cin      = c;
    hs_cyc      = cyc;
    do begin
      @(negedge clk);
      lat++;
      io_lhs      = W'($urandom);
      io_rhs      = W'($urandom);
      io_cin      = 1'($urandom);
      io_in_valid = 1'($urandom);
    end while (!io_out_valid && lat < TIMEOUT);
    io_in_valid = 1'b0;
    if (!io_out_valid) begin
      n_checks++; n_fail++;
      $display("FAIL out_valid_timeout: out_valid=%0b required 1", io_out_valid);
      ok = 1'b0;
    end
  endtask

  task automatic check_result(input string name, input logic [W-1:0] a,
                              input logic [W-1:0] b, input logic c, input int lat);
    logic [W:0] exp_v;
    exp_v = model_sum(a, b, c);
    n_checks++;
    if ({io_cout, io_out} !== exp_v) begin
      n_fail++;
      $display("FAIL %s_sum: %h+%h+%0b got cout=%0b out=%h required cout=%0b out=%h",
               name, a, b, c, io_cout, io_out, exp_v[W], exp_v[W-1:0]);
    end
    n_checks++;
    if (lat != LAT) begin
      n_fail++;
      $display("FAIL %s_latency: got %0d required %0d", name, lat, LAT);
    end
  endtask

  task automatic release_result(input string name, input logic [W:0] exp_v);
    io_out_ready = 1'b1;
    @(negedge clk);
    io_out_ready = 1'b0;
    n_checks++;
    if (io_in_ready !== 1'b1 || io_out_valid !== 1'b0 || {io_cout, io_out} !== exp_v) begin
      n_fail++;
      $display("FAIL %s_release: in_ready=%0b out_valid=%0b cout=%0b out=%h required 1 0 %0b %h",
               name, io_in_ready, io_out_valid, io_cout, io_out, exp_v[W], exp_v[W-1:0]);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    n_checks++;
    if (io_in_ready !== 1'b1 || io_out_valid !== 1'b0 || io_out !== '0 || io_cout !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state: in_ready=%0b out_valid=%0b out=%h cout=%0b required 1 0 00 0",
               io_in_ready, io_out_valid, io_out, io_cout);
    end
    @(negedge clk);
    n_checks++;
    if (io_in_ready !== 1'b1 || io_out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_hold: in_ready=%0b out_valid=%0b required 1 0", io_in_ready, io_out_valid);
    end
  endtask

  task automatic test_directed(input string name, input logic [W-1:0] a,
                               input logic [W-1:0] b, input logic c);
    int lat, hs;
    bit ok;
    issue_op(a, b, c, lat, hs, ok);
    if (!ok) return;
    check_result(name, a, b, c, lat);
    n_checks++;
    if (io_in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_in_ready_done: got %0b required 0", name, io_in_ready);
    end
    release_result(name, model_sum(a, b, c));
  endtask

  task automatic test_backpressure();
    logic [W-1:0] a, b;
    logic         c;
    logic [W:0]   exp_v;
    int lat, hs;
    bit ok;
    a = W'($urandom); b = W'($urandom); c = 1'($urandom);
    exp_v = model_sum(a, b, c);
    issue_op(a, b, c, lat, hs, ok);
    if (!ok) return;
    check_result("bp", a, b, c, lat);
    for (int i = 0; i < 3; i++) begin
      io_in_valid = 1'b1;
      io_lhs      = ~a;
      io_rhs      = ~b;
      @(negedge clk);
      io_in_valid = 1'b0;
      n_checks++;
      if (io_out_valid !== 1'b1 || io_in_ready !== 1'b0 || {io_cout, io_out} !== exp_v) begin
        n_fail++;
        $display("FAIL bp_hold%0d: out_valid=%0b in_ready=%0b cout=%0b out=%h required 1 0 %0b %h",
                 i, io_out_valid, io_in_ready, io_cout, io_out, exp_v[W], exp_v[W-1:0]);
      end
    end
    release_result("bp", exp_v);
    @(negedge clk);
    n_checks++;
    if ({io_cout, io_out} !== exp_v || io_in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_idle_keep: cout=%0b out=%h in_ready=%0b required %0b %h 1",
               io_cout, io_out, io_in_ready, exp_v[W], exp_v[W-1:0]);
    end
  endtask

  task automatic test_midop_reset();
    @(negedge clk);
    io_in_valid = 1'b1;
    io_lhs      = 8'hA7;
    io_rhs      = 8'h5C;
    io_cin      = 1'b1;
    @(negedge clk);
    io_in_valid = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    n_checks++;
    if (io_in_ready !== 1'b1 || io_out_valid !== 1'b0 || io_out !== '0 || io_cout !== 1'b0) begin
      n_fail++;
      $display("FAIL midop_reset: in_ready=%0b out_valid=%0b out=%h cout=%0b required 1 0 00 0",
               io_in_ready, io_out_valid, io_out, io_cout);
    end
    test_directed("after_reset", 8'h10, 8'h20, 1'b0);
  endtask

  task automatic test_reset_priority();
    @(negedge clk);
    io_in_valid = 1'b1;
    io_lhs      = 8'h33;
    io_rhs      = 8'h44;
    reset       = 1'b1;
    @(negedge clk);
    io_in_valid = 1'b0;
    reset       = 1'b0;
    @(negedge clk);
    n_checks++;
    if (io_in_ready !== 1'b1 || io_out !== '0) begin
      n_fail++;
      $display("FAIL reset_priority: in_ready=%0b out=%h required 1 00", io_in_ready, io_out);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 24; i++) begin
      test_directed("rand", W'($urandom), W'($urandom), 1'($urandom));
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] a [2];
    logic [W-1:0] b [2];
    logic         c [2];
    int hs [2];
    int lat;
    bit ok;
    io_out_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      a[i] = W'($urandom); b[i] = W'($urandom); c[i] = 1'($urandom);
      issue_op(a[i], b[i], c[i], lat, hs[i], ok);
      if (!ok) begin
        io_out_ready = 1'b0;
        return;
      end
      check_result("b2b", a[i], b[i], c[i], lat);
      @(negedge clk);
    end
    io_out_ready = 1'b0;
    n_checks++;
    if (hs[1] - hs[0] != LAT + 1) begin
      n_fail++;
      $display("FAIL b2b_interval: got %0d required %0d", hs[1] - hs[0], LAT + 1);
    end
  endtask

  initial begin
    reset        = 1'b0;
    io_in_valid  = 1'b0;
    io_lhs       = '0;
    io_rhs       = '0;
    io_cin       = 1'b0;
    io_out_ready = 1'b0;
    @(negedge clk);
    test_reset();
    test_directed("basic", 8'h35, 8'h4A, 1'b0);
    test_directed("ripple", 8'hFF, 8'h01, 1'b0);
    test_directed("max_cin", 8'hFF, 8'hFF, 1'b1);
    test_directed("zero", 8'h00, 8'h00, 1'b0);
    test_backpressure();
    test_midop_reset();
    test_reset_priority();
    test_random();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
